// File: rtl/bus_deskew_pkg.sv
// Shared types and width helpers for the bus_deskew lane skew compensator.
// Optional first-edge timeout is enabled with BUS_DESKEW_TIMEOUT_EN.
package bus_deskew_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TRAIN,
      LOCKED,
      ERROR
   } state_t;

   localparam int DEF_WIDTH    = 10;
   localparam int DEF_MAX_SKEW = 4;
   localparam int DEF_TIMEOUT  = 256;

   // Training pattern: hold every lane low, then raise each lane once.
   // The earliest rising edge is t0; every lane must rise within MAX_SKEW.
   function automatic int off_w(input int max_skew);
      return (max_skew < 1) ? 1 : $clog2(max_skew + 1);
   endfunction

   function automatic int cnt_w(input int max_skew);
      return $clog2(max_skew + 2);
   endfunction

endpackage

// File: rtl/bus_deskew_lane_delay.sv
// Programmable variable-delay line: STAGES-deep shift register with a
// registered tap; dout(t) = din(t-1-d), forced low while en is clear.
module lane_delay #(
   parameter int STAGES = 5,
   parameter int DW     = $clog2(STAGES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] d,
   input  logic          din,
   output logic          dout
);

   logic [STAGES-2:0] sr;
   logic [STAGES-1:0] taps;

   assign taps = {sr, din};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr   <= '0;
         dout <= 1'b0;
      end else begin
         sr   <= taps[STAGES-2:0];
         dout <= en ? taps[d] : 1'b0;
      end
   end

endmodule

// File: rtl/bus_deskew.sv
// Lane-to-lane skew compensator: trains on one rising edge per lane, then
// delays each lane so all leave MAX_SKEW+1 cycles after the earliest lane.
// Define BUS_DESKEW_TIMEOUT_EN to bound the wait for the first edge.
module bus_deskew
   import bus_deskew_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_SKEW = DEF_MAX_SKEW,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             train,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             locked,
   output logic             train_err
);

   localparam int OW = off_w(MAX_SKEW);
   localparam int CW = cnt_w(MAX_SKEW);
   localparam logic [CW-1:0] CMAX = CW'(MAX_SKEW + 1);
   localparam logic [OW-1:0] SMAX = OW'(MAX_SKEW);

   state_t state;
   logic [WIDTH-1:0] prev, seen, seen_nxt;
   logic [WIDTH-1:0] edges, fresh;
   logic [WIDTH-1:0][OW-1:0] off, off_nxt;
   logic [CW-1:0] cnt;
   logic started, meas;
   logic to_lock, to_err, to_tmo, lock_nxt;

   assign edges = in & ~prev;

   always_comb begin
      meas     = (state == TRAIN) && !train
               && !(started && cnt == CMAX);
      fresh    = meas ? (edges & ~seen) : '0;
      seen_nxt = train ? '0 : (seen | fresh);
      off_nxt  = off;
      for (int i = 0; i < WIDTH; i++) begin
         if (train)
            off_nxt[i] = '0;
         else if (fresh[i])
            off_nxt[i] = OW'(cnt);
      end
      to_lock  = meas && (&seen_nxt);
      to_err   = (state == TRAIN) && !train
               && started && (cnt == CMAX);
      lock_nxt = !train && (state == LOCKED || to_lock);
   end

`ifdef BUS_DESKEW_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] wcnt;

   assign to_tmo = (state == TRAIN) && !train && !started
                && !(|edges) && (wcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!arst_n || train)
         wcnt <= '0;
      else if (state == TRAIN && !started)
         wcnt <= wcnt + 1'b1;
   end
`else
   assign to_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state     <= IDLE;
         prev      <= '0;
         seen      <= '0;
         off       <= '0;
         cnt       <= '0;
         started   <= 1'b0;
         locked    <= 1'b0;
         out_valid <= 1'b0;
         train_err <= 1'b0;
      end else begin
         prev      <= in;
         seen      <= seen_nxt;
         off       <= off_nxt;
         locked    <= lock_nxt;
         out_valid <= lock_nxt;
         train_err <= !train
                   && (state == ERROR || to_err || to_tmo);
         if (train) begin
            state   <= TRAIN;
            cnt     <= '0;
            started <= 1'b0;
         end else begin
            unique case (state)
               TRAIN: begin
                  if (to_lock)
                     state <= LOCKED;
                  else if (to_err || to_tmo)
                     state <= ERROR;
                  // cycle t0 reads 0, so the register jumps to 1
                  if (started)
                     cnt <= cnt + 1'b1;
                  else if (|edges) begin
                     started <= 1'b1;
                     cnt     <= CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      lane_delay #(
         .STAGES(MAX_SKEW + 1)
      ) u_lane (
         .clk  (clk),
         .rst_n(arst_n),
         .en   (lock_nxt),
         .d    (SMAX - off_nxt[i]),
         .din  (in[i]),
         .dout (out[i])
      );
   end

endmodule

// File: tb/tb_bus_deskew.sv
// Randomized bench for bus_deskew with a cycle-timestamp reference model.
// Build with BUS_DESKEW_TIMEOUT_EN to exercise the first-edge timeout.
module tb_bus_deskew;

   localparam int W  = 4;
   localparam int MS = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic arst_n = 1'b0;
   logic train = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] out;
   logic out_valid, locked, train_err;

   bus_deskew #(
      .WIDTH(W),
      .MAX_SKEW(MS),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .train(train),
      .in(din),
      .out(out),
      .out_valid(out_valid),
      .locked(locked),
      .train_err(train_err)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc_n = 0;
   logic [W-1:0] hist [0:8191];
   int mst = 0;
   logic [W-1:0] mprev = '0;
   int t0 = -1;
   int entry = 0;
   int first [W];
   logic [W-1:0] e_out = '0;
   logic e_lock = 1'b0;
   logic e_err = 1'b0;
   bit chk = 1'b0;

   // Reference: timestamps of t0 and each lane's first edge.
   task automatic model(input logic tr, input logic [W-1:0] d,
                        input logic rn);
      logic [W-1:0] ed;
      bit all;
      hist[cyc_n] = d;
      if (!rn) begin
         mst = 0;
         mprev = '0;
         t0 = -1;
         for (int i = 0; i < W; i++) first[i] = -1;
      end else begin
         ed = d & ~mprev;
         if (tr) begin
            mst = 1;
            t0 = -1;
            for (int i = 0; i < W; i++) first[i] = -1;
            entry = cyc_n + 1;
         end else if (mst == 1) begin
            if (t0 < 0 && ed != 0) t0 = cyc_n;
            if (t0 >= 0 && cyc_n - t0 <= MS)
               for (int i = 0; i < W; i++)
                  if (first[i] < 0 && ed[i]) first[i] = cyc_n;
            all = 1'b1;
            for (int i = 0; i < W; i++)
               if (first[i] < 0) all = 1'b0;
            if (all) mst = 2;
            else if (t0 >= 0 && cyc_n - t0 == MS + 1) mst = 3;
`ifdef BUS_DESKEW_TIMEOUT_EN
            else if (t0 < 0 && cyc_n - entry == TO - 1) mst = 3;
`endif
         end
         mprev = d;
      end
      e_lock = (mst == 2);
      e_err = (mst == 3);
      e_out = '0;
      if (e_lock)
         for (int i = 0; i < W; i++) begin
            int k;
            k = cyc_n - (MS - (first[i] - t0));
            if (k >= 0) e_out[i] = hist[k][i];
         end
      cyc_n++;
      chk = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (chk) begin
         n_vec++;
         if (out !== e_out || out_valid !== e_lock
             || locked !== e_lock || train_err !== e_err) begin
            n_err++;
            $display("FAIL cycle %0d: out=%b v=%b lk=%b err=%b want out=%b v=%b lk=%b err=%b",
                     cyc_n, out, out_valid, locked, train_err,
                     e_out, e_lock, e_lock, e_err);
         end
      end
   end

   task automatic cyc(input logic tr, input logic [W-1:0] d);
      @(negedge clk);
      arst_n = 1'b1;
      train = tr;
      din = d;
      model(tr, d, 1'b1);
   endtask

   task automatic rcyc();
      @(negedge clk);
      arst_n = 1'b0;
      train = 1'b0;
      din = '0;
      model(1'b0, '0, 1'b0);
   endtask

   task automatic lit(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic train_pattern(input int offs [W]);
      logic [W-1:0] d;
      int maxo;
      maxo = 0;
      for (int i = 0; i < W; i++) if (offs[i] > maxo) maxo = offs[i];
      cyc(1'b1, '0);
      cyc(1'b0, '0);
      for (int k = 0; k <= maxo; k++) begin
         for (int i = 0; i < W; i++) d[i] = (k >= offs[i]);
         cyc(1'b0, d);
      end
      cyc(1'b0, '1);
      cyc(1'b0, '1);
   endtask

   task automatic rand_data(input int n);
      for (int j = 0; j < n; j++) cyc(1'b0, W'($urandom));
   endtask

   initial begin
      int o1 [W];
      int oz [W];
      int o4 [W];
      int o5 [W];
      int orr [W];
      logic [W-1:0] d;
      logic [W-1:0] wd;
      o1 = '{0, 2, 1, 4};
      oz = '{0, 0, 0, 0};
      o4 = '{0, 1, 1, 0};
      o5 = '{1, 0, 3, 2};
      wd = 4'b1010;

      rcyc();
      rcyc();
      after_edge();
      lit("reset_locked", int'(locked), 0);
      lit("reset_out", int'(out), 0);
      repeat (3) cyc(1'b0, '0);

      // lanes rise at t0, t0+2, t0+1, t0+4
      cyc(1'b1, '0);
      cyc(1'b0, '0);
      for (int k = 0; k <= 4; k++) begin
         for (int i = 0; i < W; i++) d[i] = (k >= o1[i]);
         cyc(1'b0, d);
      end
      after_edge();
      lit("lock_t0p5", int'(locked), 1);
      lit("d_lane0", MS - (first[0] - t0), 4);
      lit("d_lane1", MS - (first[1] - t0), 2);
      lit("d_lane2", MS - (first[2] - t0), 3);
      lit("d_lane3", MS - (first[3] - t0), 0);
      for (int j = 0; j <= 8; j++) begin
         for (int i = 0; i < W; i++)
            d[i] = (j == 2 + o1[i]) ? wd[i] : 1'b0;
         cyc(1'b0, d);
         if (j == 6) begin
            after_edge();
            lit("aligned_word", int'(out), int'(wd));
         end
      end
      rand_data(10);

      // all lanes at t0
      train_pattern(oz);
      lit("d_all4", MS - (first[3] - t0), 4);
      rand_data(15);

      // lane 3 never rises
      cyc(1'b1, '0);
      cyc(1'b0, '0);
      for (int k = 0; k <= 6; k++) begin
         cyc(1'b0, 4'b0111);
         if (k == 4) begin
            after_edge();
            lit("err_t0p5", int'(train_err), 0);
         end
         if (k == 5) begin
            after_edge();
            lit("err_t0p6", int'(train_err), 1);
         end
      end

      // edge coincident with train is discarded
      cyc(1'b0, '0);
      cyc(1'b1, 4'b0001);
      cyc(1'b0, 4'b0011);
      cyc(1'b0, 4'b0010);
      cyc(1'b0, 4'b1111);
      after_edge();
      lit("coinc_lock", int'(locked), 1);
      lit("coinc_off0", first[0] - t0, 2);
      rand_data(8);

      // retrain while locked
      train_pattern(o4);
      lit("re_d1", MS - (first[1] - t0), 3);
      lit("re_d0", MS - (first[0] - t0), 4);
      rand_data(10);

      // reset mid-training at t0+2
      cyc(1'b1, '0);
      cyc(1'b0, '0);
      cyc(1'b0, 4'b0001);
      cyc(1'b0, 4'b0011);
      rcyc();
      after_edge();
      lit("rst_locked", int'(locked), 0);
      lit("rst_err", int'(train_err), 0);
      train_pattern(o5);
      lit("relock", int'(locked), 1);
      rand_data(10);

      // randomized training passes, some with an out-of-range lane
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < W; i++) orr[i] = $urandom_range(MS, 0);
         if ($urandom_range(3, 0) == 0)
            orr[$urandom_range(W - 1, 0)] = MS + 1;
         train_pattern(orr);
         rand_data(8);
      end

      // no edges after train
      cyc(1'b1, '0);
      repeat (30) cyc(1'b0, '0);
      after_edge();
`ifdef BUS_DESKEW_TIMEOUT_EN
      lit("tmo_err", int'(train_err), 1);
`else
      lit("no_tmo_err", int'(train_err), 0);
`endif
      lit("no_edge_lock", int'(locked), 0);

      @(negedge clk);
      chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
